// File: rtl/rng_share_arb.sv
// Shares one Mersenne-Twister word source among NREQ requesters: owns the rng reset/start
// pulses, prefetches words into a DEPTH-entry FIFO and hands each word to one requester round-robin.
module rng_share_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          gnt,
   output logic [31:0]              rand_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     rng_rst,
   output logic                     rng_start,
   input  logic                     rng_valid,
   input  logic [31:0]              rng_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = $clog2(NREQ);

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_KICK = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rst_sync;
   logic              r_rng_rst;
   logic              r_rng_start;
   logic              w_start_nxt;
   logic              w_push;
   logic              w_pop;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   w_gnt_nxt;
   logic [NREQ-1:0]   w_elig;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     w_ptr_nxt;
   logic [31:0]       r_rand;
   logic [AW:0]       r_level;
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [31:0]       r_mem [DEPTH];

   assign gnt       = r_gnt;
   assign rand_data = r_rand;
   assign level     = r_level;
   assign rng_rst   = r_rng_rst;
   assign rng_start = r_rng_start;

   // Refill sequencer: a word is pushed only in WAIT; KICK masks the still-high rng_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (rng_valid && !r_rng_rst && enable && (r_level < (AW+1)'(DEPTH))) begin
               w_push      = 1'b1;
               w_start_nxt = 1'b1;
               w_state_nxt = ST_KICK;
            end
         end
         ST_KICK: begin
            w_state_nxt = ST_WAIT;
         end
         default: begin
            w_state_nxt = ST_WAIT;
         end
      endcase
   end

   // Round-robin pick starting at r_ptr; a requester just granted sits out one cycle.
   always_comb begin
      logic [31:0] idx;
      logic        found;
      w_elig    = req & ~r_gnt;
      w_gnt_nxt = '0;
      w_ptr_nxt = r_ptr;
      idx       = '0;
      found     = 1'b0;
      if (r_level != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (32'(r_ptr) + 32'(k)) % 32'(NREQ);
            if (!found && w_elig[PW'(idx)]) begin
               found                = 1'b1;
               w_gnt_nxt[PW'(idx)]  = 1'b1;
               w_ptr_nxt            = PW'((idx + 32'd1) % 32'(NREQ));
            end
         end
      end
   end

   assign w_pop = |w_gnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_WAIT;
         r_rst_sync  <= 1'b0;
         r_rng_rst   <= 1'b1;
         r_rng_start <= 1'b0;
         r_gnt       <= '0;
         r_ptr       <= '0;
         r_rand      <= '0;
         r_level     <= '0;
         r_wr        <= '0;
         r_rd        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rst_sync  <= 1'b1;
         r_rng_rst   <= ~r_rst_sync;
         r_rng_start <= w_start_nxt;
         r_gnt       <= w_gnt_nxt;
         r_ptr       <= w_ptr_nxt;
         if (w_pop) begin
            r_rand <= r_mem[r_rd];
            r_rd   <= r_rd + AW'(1);
         end
         if (w_push) begin
            r_wr <= r_wr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= rng_data;
      end
   end

endmodule

// File: tb/tb_rng_share_arb.sv
// Bench for rng_share_arb: behavioural MT19937 word source plus an occupancy/round-robin model
// checked every cycle, and directed boot, fairness, boundary, enable and mid-run reset scenarios.
module tb_rng_share_arb;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DEPTH = 8;
   localparam int NW      = 2048;
   localparam int BOOT    = 3120;
   localparam int WORDLAT = 0;
   localparam int REGEN   = 600;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [3:0]  gnt;
   logic [31:0] rand_data;
   logic [3:0]  level;
   logic        rng_rst;
   logic        rng_start;
   logic        rng_valid;
   logic [31:0] rng_data;

   int errors = 0;
   int checks = 0;

   rng_share_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .gnt(gnt),
      .rand_data(rand_data), .level(level), .rng_rst(rng_rst), .rng_start(rng_start),
      .rng_valid(rng_valid), .rng_data(rng_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mt_words [NW];

   task automatic gen_mt();
      logic [31:0] mt [624];
      logic [31:0] y;
      int mi;
      mt[0] = 32'd5489;
      for (int i = 1; i < 624; i++) mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
      mi = 624;
      for (int n = 0; n < NW; n++) begin
         if (mi == 624) begin
            for (int i = 0; i < 624; i++) begin
               y = (mt[i] & 32'h8000_0000) | (mt[(i+1)%624] & 32'h7fff_ffff);
               mt[i] = mt[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
            end
            mi = 0;
         end
         y = mt[mi];
         mi++;
         y = y ^ (y >> 11);
         y = y ^ ((y << 7) & 32'h9d2c_5680);
         y = y ^ ((y << 15) & 32'hefc6_0000);
         y = y ^ (y >> 18);
         mt_words[n] = y;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Word source: valid holds until a start is seen, next word after a delay, long stall every 624.
   int   s_idx = 0;
   int   s_cnt = BOOT;
   logic s_valid = 1'b0;
   always @(posedge clk) begin
      if (rng_rst === 1'b1) begin
         s_valid <= 1'b0;
         s_idx   <= 0;
         s_cnt   <= BOOT;
      end else if (s_valid) begin
         if (rng_start) begin
            s_valid <= 1'b0;
            s_idx   <= s_idx + 1;
            s_cnt   <= (((s_idx + 1) % 624) == 0) ? REGEN : WORDLAT;
         end
      end else if (s_cnt == 0) begin
         s_valid <= 1'b1;
      end else begin
         s_cnt <= s_cnt - 1;
      end
   end
   assign rng_valid = s_valid;
   assign rng_data  = mt_words[s_idx];

   // Cycle model built from the observable rules: occupancy count, RR pointer, word index.
   int          exp_level = 0, exp_ptr = 0, exp_idx = 0, rst_edges = 0, win = 0;
   logic [31:0] exp_data = '0;
   logic        p_start = 0, p_valid = 0, p_en = 0, p_rngrst = 1, p_rstn = 0;
   logic        e_start, e_rngrst;
   logic [3:0]  p_req = '0, p_gnt = '0, e_gnt, elig;
   logic [31:0] push_log [$];
   logic [31:0] deliv_log [$];
   int          deliv_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_level = 0; exp_ptr = 0; exp_idx = 0; exp_data = '0; rst_edges = 0;
         p_start = 0; p_valid = 0; p_en = 0; p_rngrst = 1; p_rstn = 0; p_req = '0; p_gnt = '0;
      end else begin
         if (p_rstn && rst_edges < 2) rst_edges++;
         e_rngrst = (rst_edges < 2);
         e_start  = !p_start && p_valid && p_en && !p_rngrst && (exp_level < DEPTH);
         e_gnt    = '0;
         win      = -1;
         if (exp_level > 0) begin
            elig = p_req & ~p_gnt;
            for (int k = 0; k < NREQ; k++) begin
               if (win < 0 && elig[(exp_ptr + k) % NREQ]) win = (exp_ptr + k) % NREQ;
            end
         end
         if (win >= 0) begin
            e_gnt[win] = 1'b1;
            exp_ptr    = (win + 1) % NREQ;
            exp_data   = mt_words[exp_idx];
            exp_idx++;
         end
         exp_level = exp_level + (e_start ? 1 : 0) - ((win >= 0) ? 1 : 0);
         check("rng_rst",   32'(rng_rst),   32'(e_rngrst));
         check("rng_start", 32'(rng_start), 32'(e_start));
         check("gnt",       32'(gnt),       32'(e_gnt));
         check("rand_data", rand_data,      exp_data);
         check("level",     32'(level),     32'(exp_level));
         if (rng_start) push_log.push_back(rng_data);
         if (gnt != '0) begin
            deliv_log.push_back(rand_data);
            deliv_cnt++;
         end
         p_start = e_start; p_valid = rng_valid; p_en = enable; p_rngrst = e_rngrst;
         p_rstn = rst_n; p_req = req; p_gnt = e_gnt;
      end
   end

   task automatic wait_level(input string name, input int target, input int limit);
      int n = 0;
      while (32'(level) != 32'(target) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(level), 32'(target));
   endtask

   initial begin
      int n, cnt, base, psz;
      gen_mt();
      check("model_w0", mt_words[0], 32'd3499211612);
      check("model_w1", mt_words[1], 32'd581869302);
      check("model_w2", mt_words[2], 32'd3890346734);

      // Reset and boot
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",   32'(gnt),       32'd0);
      check("rst_level", 32'(level),     32'd0);
      check("rst_start", 32'(rng_start), 32'd0);
      check("rst_rngrst", 32'(rng_rst),  32'd1);
      check("rst_data",  rand_data,      32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_level("t1_fill", 8, BOOT + 200);
      check("t1_push0", push_log[0], 32'd3499211612);
      check("t1_push1", push_log[1], 32'd581869302);
      check("t1_push2", push_log[2], 32'd3890346734);
      repeat (30) @(negedge clk);
      check("t1_hold", 32'(level), 32'd8);

      // Single requester: one word every other cycle
      @(posedge clk); #1;
      req = 4'b0001;
      cnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (gnt[0]) cnt++;
      end
      req = 4'b0000;
      check("t2_rate", 32'(cnt), 32'd10);
      check("t2_word0", deliv_log[0], 32'd3499211612);
      check("t2_word1", deliv_log[1], 32'd581869302);
      check("t2_word2", deliv_log[2], 32'd3890346734);

      // All requesting across a regeneration stall
      @(posedge clk); #1;
      req  = 4'b1111;
      base = deliv_cnt;
      n    = 0;
      while (deliv_cnt < base + 1300 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      check("t3_words", 32'(deliv_cnt >= base + 1300), 32'd1);
      @(posedge clk); #1;
      req = 4'b0000;

      // Full boundary: one pop while full triggers exactly one refill
      n = 0;
      while (!(level == 4'd8 && rng_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t4_full_valid", 32'(level == 4'd8 && rng_valid), 32'd1);
      psz = push_log.size();
      @(posedge clk); #1;
      req = 4'b0010;
      @(posedge clk); #1;
      req = 4'b0000;
      check("t4_pop", 32'(gnt), 32'b0010);
      wait_level("t4_refill", 8, 10);
      check("t4_one_push", 32'(push_log.size() - psz), 32'd1);

      // Enable low drains, enable high resumes
      @(posedge clk); #1;
      enable = 1'b0;
      req    = 4'b0100;
      wait_level("t5_drain", 0, 200);
      psz = push_log.size();
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (gnt != '0) cnt++;
      end
      check("t5_no_gnt",  32'(cnt), 32'd0);
      check("t5_no_push", 32'(push_log.size() - psz), 32'd0);
      @(posedge clk); #1;
      enable = 1'b1;
      n = 0;
      while (!gnt[2] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t5_resume", 32'(gnt[2]), 32'd1);

      // Mid-run reset during the start pulse
      @(posedge clk); #1;
      req = 4'b0001;
      n = 0;
      while (!rng_start && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_kick", 32'(rng_start), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_gnt",    32'(gnt),       32'd0);
      check("t6_start",  32'(rng_start), 32'd0);
      check("t6_level",  32'(level),     32'd0);
      check("t6_rngrst", 32'(rng_rst),   32'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      while (!gnt[0] && n < BOOT + 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_first_gnt",  32'(gnt[0]), 32'd1);
      check("t6_first_word", rand_data,    32'd3499211612);
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (10) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
